// File: rtl/nn_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nn_seq_pkg
// Purpose : Shared definitions for the layer sequencer: FSM state encoding,
//           a width helper used for parameter defaults, and the default
//           watchdog limit.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package nn_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_FIN   = 3'd5,
    ST_ERR   = 3'd6
  } seq_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 1023;

  // Smallest width w (>= 1) such that 2**w >= n.
  function automatic int unsigned bits_for(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/layer_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : layer_watchdog
// Purpose : Cycle counter guarding the WAIT state. Cleared by clr, counts
//           while en is high, and flags expiry on the last permitted cycle.
// Ports   : CLOCK   in  system clock, rising edge
//           reset   in  synchronous active-high reset
//           clr     in  zero the counter (takes priority over en)
//           en      in  count this cycle
//           expired out high when count == TIMEOUT-1 and en
// Revision: 1.0 - initial release
// ============================================================================
module layer_watchdog
  import nn_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned TO_W    = bits_for(TIMEOUT + 1)
) (
  input  logic CLOCK,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] c_LAST_COUNT = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + TO_W'(1);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // en is decoded from the sequencer's registered state, so this stays
  // free of any path from a primary input.
  assign expired = en && (count_q == c_LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : layer_sequencer
// Purpose : Steps a network through its layers. For each layer it clears the
//           compute units, pulses start, then waits for the combined
//           all-units-done pulse. After the last layer it pulses net_done.
//           A watchdog parks the sequencer in ERR if a layer hangs.
// Ports   : CLOCK       in  system clock, rising edge
//           reset       in  synchronous active-high reset
//           go          in  start an inference (IDLE or ERR only)
//           all_done    in  one-cycle completion pulse (WAIT only)
//           unit_clear  out one-cycle clear of the units' done flags
//           unit_start  out one-cycle start of the current layer
//           layer       out current layer index
//           busy        out high in CLEAR/START/WAIT/NEXT/FIN
//           net_done    out one-cycle pulse when the final layer is done
//           timeout_err out sticky watchdog error, cleared by go
// Revision: 1.0 - initial release
// ============================================================================
module layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned LAYER_W    = bits_for(NUM_LAYERS),
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT,
  parameter int unsigned TO_W       = bits_for(TIMEOUT + 1)
) (
  input  logic               CLOCK,
  input  logic               reset,
  input  logic               go,
  input  logic               all_done,
  output logic               unit_clear,
  output logic               unit_start,
  output logic [LAYER_W-1:0] layer,
  output logic               busy,
  output logic               net_done,
  output logic               timeout_err
);

  localparam logic [LAYER_W-1:0] c_LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  seq_state_e         state_q;
  seq_state_e         state_d;
  logic [LAYER_W-1:0] layer_q;
  logic [LAYER_W-1:0] layer_d;
  logic               wd_expired;

  layer_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .CLOCK   (CLOCK),
    .reset   (reset),
    .clr     (state_q == ST_START),
    .en      (state_q == ST_WAIT),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    unique case (state_q)
      ST_IDLE, ST_ERR: begin
        if (go) begin
          state_d = ST_CLEAR;
          layer_d = '0;
        end
      end
      ST_CLEAR: state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // A completion arriving on the expiry cycle still counts.
        if (all_done) begin
          state_d = ST_NEXT;
        end else if (wd_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_NEXT: begin
        if (layer_q == c_LAST_LAYER) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_CLEAR;
          layer_d = layer_q + LAYER_W'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_q <= ST_IDLE;
      layer_q <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
    end
  end

  // All outputs are pure decodes of registered state.
  assign unit_clear  = (state_q == ST_CLEAR);
  assign unit_start  = (state_q == ST_START);
  assign net_done    = (state_q == ST_FIN);
  assign timeout_err = (state_q == ST_ERR);
  assign busy        = (state_q == ST_CLEAR) || (state_q == ST_START) ||
                       (state_q == ST_WAIT)  || (state_q == ST_NEXT)  ||
                       (state_q == ST_FIN);
  assign layer       = layer_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_layer_sequencer
// Purpose : Self-checking bench for layer_sequencer. Instance A runs three
//           layers with a 16-cycle watchdog; instance B runs a single layer.
//           Expected event cycles are computed from the sequencing rules
//           (per-layer cost, latency from go, watchdog length).
// Revision: 1.0 - initial release
// ============================================================================
module tb_layer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       go_a, done_a, go_b, done_b;
  logic       clr_a, start_a, busy_a, nd_a, err_a;
  logic [1:0] layer_a;
  logic       clr_b, start_b, busy_b, nd_b, err_b;
  logic [0:0] layer_b;

  layer_sequencer #(.NUM_LAYERS(3), .TIMEOUT(16)) dut_a (
    .CLOCK(clk), .reset(rst), .go(go_a), .all_done(done_a),
    .unit_clear(clr_a), .unit_start(start_a), .layer(layer_a),
    .busy(busy_a), .net_done(nd_a), .timeout_err(err_a)
  );

  layer_sequencer #(.NUM_LAYERS(1), .TIMEOUT(16)) dut_b (
    .CLOCK(clk), .reset(rst), .go(go_b), .all_done(done_b),
    .unit_clear(clr_b), .unit_start(start_b), .layer(layer_b),
    .busy(busy_b), .net_done(nd_b), .timeout_err(err_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Event log for instance A, sampled mid-cycle.
  bit mon_en = 1'b0;
  int q_clear[$];
  int q_start[$];
  int q_slayer[$];
  int q_done[$];
  always @(negedge clk) begin
    if (mon_en) begin
      if (clr_a) q_clear.push_back(cyc);
      if (start_a) begin
        q_start.push_back(cyc);
        q_slayer.push_back(int'(layer_a));
      end
      if (nd_a) q_done.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if ({clr_a, start_a, busy_a, nd_a, err_a} !== 5'b0) begin
      n_bad++; $display("FAIL reset_outs_a: got %b want 00000", {clr_a, start_a, busy_a, nd_a, err_a});
    end
    n_cmp++; if (layer_a !== 2'd0) begin
      n_bad++; $display("FAIL reset_layer_a: got %0d want 0", layer_a);
    end
    n_cmp++; if ({clr_b, start_b, busy_b, nd_b, err_b} !== 5'b0) begin
      n_bad++; $display("FAIL reset_outs_b: got %b want 00000", {clr_b, start_b, busy_b, nd_b, err_b});
    end
    n_cmp++; if (layer_b !== 1'b0) begin
      n_bad++; $display("FAIL reset_layer_b: got %0d want 0", layer_b);
    end
    rst = 1'b0;
    tick();
  endtask

  // Full three-layer inference on A; all_done arrives d[i] cycles after each
  // unit_start. With noise, all_done is also pulsed in every CLEAR cycle and
  // go is toggled randomly while busy; neither may change anything.
  task automatic test_layers(input int d0, input int d1, input int d2, input bit noise);
    int d[3];
    int es[3];
    int ad[3];
    int g, ed;
    bit err_seen;
    d[0] = d0; d[1] = d1; d[2] = d2;
    q_clear.delete(); q_start.delete(); q_slayer.delete(); q_done.delete();
    err_seen = 1'b0;
    g = cyc;
    es[0] = g + 2;
    for (int i = 0; i < 3; i++) begin
      ad[i] = es[i] + d[i];
      if (i < 2) es[i+1] = es[i] + d[i] + 3;
    end
    ed = ad[2] + 2;
    mon_en = 1'b1;
    go_a = 1'b1;
    while (cyc < ed + 2) begin
      tick();
      go_a = noise && (cyc <= ed) && ($urandom_range(1, 0) == 1);
      done_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (cyc == ad[i]) done_a = 1'b1;
        if (noise && (cyc == es[i] - 1)) done_a = 1'b1;
      end
      if (err_a) err_seen = 1'b1;
      if (cyc == ed) begin
        n_cmp++; if (busy_a !== 1'b1) begin
          n_bad++; $display("FAIL busy_at_fin: got %b want 1", busy_a);
        end
      end
      if (cyc == ed + 1) begin
        n_cmp++; if (busy_a !== 1'b0) begin
          n_bad++; $display("FAIL busy_after_fin: got %b want 0", busy_a);
        end
        n_cmp++; if (layer_a !== 2'd2) begin
          n_bad++; $display("FAIL layer_hold: got %0d want 2", layer_a);
        end
      end
    end
    go_a = 1'b0; done_a = 1'b0; mon_en = 1'b0;
    n_cmp++; if (q_start.size() !== 3) begin
      n_bad++; $display("FAIL start_count: got %0d want 3", q_start.size());
    end
    for (int i = 0; i < 3 && i < q_start.size(); i++) begin
      n_cmp++; if (q_start[i] !== es[i]) begin
        n_bad++; $display("FAIL start_cycle[%0d]: got %0d want %0d", i, q_start[i] - g, es[i] - g);
      end
      n_cmp++; if (q_slayer[i] !== i) begin
        n_bad++; $display("FAIL start_layer[%0d]: got %0d want %0d", i, q_slayer[i], i);
      end
    end
    n_cmp++; if (q_clear.size() !== 3) begin
      n_bad++; $display("FAIL clear_count: got %0d want 3", q_clear.size());
    end
    for (int i = 0; i < 3 && i < q_clear.size(); i++) begin
      n_cmp++; if (q_clear[i] !== es[i] - 1) begin
        n_bad++; $display("FAIL clear_cycle[%0d]: got %0d want %0d", i, q_clear[i] - g, es[i] - 1 - g);
      end
    end
    n_cmp++; if (q_done.size() !== 1) begin
      n_bad++; $display("FAIL net_done_count: got %0d want 1", q_done.size());
    end else begin
      n_cmp++; if (q_done[0] !== ed) begin
        n_bad++; $display("FAIL net_done_cycle: got %0d want %0d", q_done[0] - g, ed - g);
      end
    end
    n_cmp++; if (err_seen !== 1'b0) begin
      n_bad++; $display("FAIL no_timeout: got %b want 0", err_seen);
    end
  endtask

  task automatic test_timeout();
    int g, nwait, hold;
    g = cyc;
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    nwait = 0;
    while (cyc <= g + 18) begin
      if (busy_a && !clr_a && !start_a) nwait++;
      if (cyc == g + 18) begin
        n_cmp++; if (err_a !== 1'b0) begin
          n_bad++; $display("FAIL err_early: got %b want 0", err_a);
        end
      end
      tick();
    end
    n_cmp++; if (nwait !== 16) begin
      n_bad++; $display("FAIL wait_cycles: got %0d want 16", nwait);
    end
    n_cmp++; if ({err_a, busy_a, layer_a} !== 4'b1000) begin
      n_bad++; $display("FAIL err_state: got err=%b busy=%b layer=%0d want err=1 busy=0 layer=0", err_a, busy_a, layer_a);
    end
    hold = $urandom_range(5, 1);
    repeat (hold) tick();
    n_cmp++; if ({err_a, busy_a} !== 2'b10) begin
      n_bad++; $display("FAIL err_sticky: got err=%b busy=%b want err=1 busy=0", err_a, busy_a);
    end
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    n_cmp++; if ({clr_a, err_a, busy_a, layer_a} !== 5'b10100) begin
      n_bad++; $display("FAIL err_restart: got clr=%b err=%b busy=%b layer=%0d want clr=1 err=0 busy=1 layer=0", clr_a, err_a, busy_a, layer_a);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ignored();
    bit moved;
    moved = 1'b0;
    for (int i = 0; i < 6; i++) begin
      done_a = (i == 0) || ($urandom_range(1, 0) == 1);
      tick();
      if (busy_a || start_a || clr_a || nd_a) moved = 1'b1;
    end
    done_a = 1'b0;
    tick();
    n_cmp++; if (moved !== 1'b0 || busy_a !== 1'b0) begin
      n_bad++; $display("FAIL idle_all_done: got moved=%b busy=%b want 0 0", moved, busy_a);
    end
    test_layers($urandom_range(12, 1), $urandom_range(12, 1), $urandom_range(12, 1), 1'b1);
  endtask

  task automatic test_reset_mid();
    int g, d0, es1;
    g = cyc;
    d0 = $urandom_range(8, 1);
    es1 = g + 2 + d0 + 3;
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    while (cyc < es1 + 2) begin
      done_a = (cyc == g + 2 + d0);
      tick();
    end
    done_a = 1'b0;
    n_cmp++; if ({busy_a, layer_a} !== 3'b101) begin
      n_bad++; $display("FAIL mid_wait: got busy=%b layer=%0d want busy=1 layer=1", busy_a, layer_a);
    end
    rst = 1'b1;
    tick();
    n_cmp++; if ({clr_a, start_a, busy_a, nd_a, err_a, layer_a} !== 7'b0) begin
      n_bad++; $display("FAIL mid_reset: got %b want 0000000", {clr_a, start_a, busy_a, nd_a, err_a, layer_a});
    end
    rst = 1'b0;
    tick();
    n_cmp++; if (busy_a !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_idle: got busy=%b want 0", busy_a);
    end
    test_layers($urandom_range(12, 1), $urandom_range(12, 1), $urandom_range(12, 1), 1'b0);
  endtask

  task automatic test_single();
    int g, nd_cnt, nd_t, st_t, nd_layer;
    g = cyc;
    go_b = 1'b1;
    tick();
    go_b = 1'b0;
    nd_cnt = 0; nd_t = -1; st_t = -1; nd_layer = -1;
    while (cyc <= g + 8) begin
      done_b = (cyc == g + 3);
      if (nd_b) begin
        nd_cnt++; nd_t = cyc; nd_layer = int'(layer_b);
      end
      if (start_b && st_t < 0) st_t = cyc;
      tick();
    end
    done_b = 1'b0;
    n_cmp++; if (st_t !== g + 2) begin
      n_bad++; $display("FAIL single_start: got %0d want 2", st_t - g);
    end
    n_cmp++; if (nd_cnt !== 1 || nd_t !== g + 5) begin
      n_bad++; $display("FAIL single_net_done: got count=%0d at %0d want count=1 at 5", nd_cnt, nd_t - g);
    end
    n_cmp++; if (nd_layer !== 0 || busy_b !== 1'b0) begin
      n_bad++; $display("FAIL single_end: got layer=%0d busy=%b want 0 0", nd_layer, busy_b);
    end
  endtask

  initial begin
    rst = 1'b1;
    go_a = 1'b0; done_a = 1'b0; go_b = 1'b0; done_b = 1'b0;
    test_reset();
    test_layers(5, 5, 5, 1'b0);
    test_layers(1, 1, 1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      test_layers($urandom_range(12, 1), $urandom_range(12, 1), $urandom_range(12, 1), 1'b0);
    end
    test_timeout();
    test_layers(16, 16, 16, 1'b0);
    test_layers(16, 1, 16, 1'b0);
    test_ignored();
    test_reset_mid();
    test_single();
    test_single();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
